xm_pipe_stage: RTL and testbench
================================

Name: xm_pipe_stage

Overview:
Parametrised execute-to-memory pipeline stage; successor to the plain enable-gated EX/MEM register. Carries PC, instruction, memory address, store data and memory controls from execute to memory. Adds valid/ready handshake, a 2-entry skid buffer so in_ready is registered and throughput stays at 1/cycle, a synchronous flush for branch/exception kill, and a saturating stall counter.

Parameters:
DATA_W, 32, width of pc, instr, address, data fields
STALL_CNT_W, 16, width of stall_count

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  execute side offers a transfer
in_ready  out  1  stage can accept (registered)
in_pc  in  DATA_W  PC of offered instruction
in_instr  in  DATA_W  instruction word
in_address  in  DATA_W  memory address
in_data  in  DATA_W  store data
in_mem_read_write  in  1  1 = write, 0 = read
in_mem_enable  in  1  memory access requested
out_valid  out  1  memory side has a valid entry
out_ready  in  1  memory side consumes entry
out_pc, out_instr, out_address, out_data  out  DATA_W each  head-entry fields
out_mem_read_write  out  1  head-entry direction
out_mem_enable  out  1  head-entry enable, gated by out_valid
stall_count  out  STALL_CNT_W  cycles with out_valid=1, out_ready=0

Behaviour:
- Reset (reset_n=0, asynchronous): main_valid=0, skid_valid=0, all payload registers 0, stall_count=0, in_ready=1 once reset releases; out_valid=0, out_mem_enable=0.
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = ~skid_valid, taken from a register, never combinationally from out_ready.
- Main register (head) drives out_*; out_valid = main_valid.
- Main loads when ~main_valid or consume: from skid if skid_valid (skid_valid clears), else from input if accept, else main_valid goes 0.
- Accept while main is held (main_valid & ~out_ready): entry goes to skid, skid_valid=1, so in_ready=0 next cycle.
- Latency: accept into empty stage -> out_valid=1 the next cycle. Order is strictly FIFO. Sustained 1 transfer/cycle when out_ready=1.
- Simultaneous consume + accept with skid empty: main takes the input and main_valid stays 1.
- Simultaneous consume + accept with skid full: impossible, since in_ready=0.
- out_mem_enable = main_mem_enable & main_valid; bubbles never issue memory accesses.
- Payload registers load only when the slot loads. Held payload is stable while out_valid & ~out_ready.
- flush=1: next cycle main_valid=0, skid_valid=0, in_ready=1. An input accepted in the flush cycle is discarded. A consume in the flush cycle still counts as completed. Payload values are not cleared.
- flush dominates all loads in the same cycle.
- stall_count increments each cycle out_valid & ~out_ready and saturates at all-ones; flush does not clear it, only reset does.
- Reset asserted mid-transfer: all state cleared immediately; no partial entry survives.

Decomposition:
- Shared package: typedef of the stage payload struct (pc, instr, address, data, mem_read_write, mem_enable) parametrised via DATA_W; constants MEM_READ=0, MEM_WRITE=1.
- One natural sub-module: pipe_skid_buffer, a generic payload-width valid/ready 2-entry skid with flush. xm_pipe_stage wraps it and adds output gating and the stall counter.

Test Plan:
- Reset then idle: reset_n=0 with in_valid=1 -> out_valid=0, out_mem_enable=0, stall_count=0, in_ready=1 after release.
- Single transfer: in_pc=0x100, in_instr=0xAC220004, in_address=0x2000, in_data=0xDEADBEEF, in_mem_enable=1, in_mem_read_write=1, out_ready=1 -> next cycle out_valid=1 with identical fields, out_mem_enable=1.
- Back-pressure: stream pc=0x0,0x4,0x8; out_ready=0 for 3 cycles -> after 2 accepts in_ready=0, stall_count=3, outputs hold pc=0x0. Raise out_ready -> 0x0,0x4,0x8 emerge in order, one per cycle, none lost or duplicated.
- Flush with full skid: main=0x10, skid=0x14, flush=1 with in_valid=1 (pc=0x18) -> next cycle out_valid=0, in_ready=1; 0x14 and 0x18 never appear.
- Bubble gating: main holds mem_enable=1, consume with no new input -> out_valid=0 and out_mem_enable=0 the following cycle.
- Counter saturation: STALL_CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_count=15 and stays 15.

Source files
------------

// File: rtl/xm_pipe_stage_pkg.sv
// Shared types and constants for the execute-to-memory pipeline stage.
// The payload is flattened as {pc, instr, address, data, mem_read_write, mem_enable}.
package xm_pipe_stage_pkg;

  localparam int XM_DATA_W = 32;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef struct packed {
    logic [XM_DATA_W-1:0] pc;
    logic [XM_DATA_W-1:0] instr;
    logic [XM_DATA_W-1:0] address;
    logic [XM_DATA_W-1:0] data;
    logic                 mem_read_write;
    logic                 mem_enable;
  } xm_payload_t;

  function automatic int xm_payload_w(input int dw);
    return 4 * dw + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// in_ready depends only on registered state, never on out_ready.
module pipe_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         main_valid;
  logic         skid_valid;
  logic [W-1:0] main_payload;
  logic [W-1:0] skid_payload;

  logic accept;
  logic consume;
  logic main_load;

  assign in_ready    = ~skid_valid;
  assign out_valid   = main_valid;
  assign out_payload = main_payload;

  assign accept    = in_valid & in_ready;
  assign consume   = main_valid & out_ready;
  assign main_load = ~main_valid | consume;

  // Skid only fills while the head is held, so it is never full during a consume+accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid   <= 1'b0;
      skid_valid   <= 1'b0;
      main_payload <= '0;
      skid_payload <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_load) begin
      if (skid_valid) begin
        main_payload <= skid_payload;
        main_valid   <= 1'b1;
        skid_valid   <= 1'b0;
      end else if (accept) begin
        main_payload <= in_payload;
        main_valid   <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_payload <= in_payload;
      skid_valid   <= 1'b1;
    end
  end

endmodule

// File: rtl/xm_pipe_stage.sv
// Execute-to-memory pipeline stage: skid-buffered handshake, bubble-gated
// memory enable and a saturating back-pressure counter.
module xm_pipe_stage
  import xm_pipe_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_pc,
  input  logic [DATA_W-1:0]      in_instr,
  input  logic [DATA_W-1:0]      in_address,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_mem_read_write,
  input  logic                   in_mem_enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_pc,
  output logic [DATA_W-1:0]      out_instr,
  output logic [DATA_W-1:0]      out_address,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_mem_read_write,
  output logic                   out_mem_enable,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int PW = xm_payload_w(DATA_W);

  logic [PW-1:0] in_payload;
  logic [PW-1:0] head_payload;
  logic          head_mem_enable;
  logic          stalled;

  assign in_payload = {in_pc, in_instr, in_address, in_data,
                       in_mem_read_write, in_mem_enable};

  pipe_skid_buffer #(
    .W (PW)
  ) u_skid (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (head_payload)
  );

  assign {out_pc, out_instr, out_address, out_data,
          out_mem_read_write, head_mem_enable} = head_payload;

  // A bubble must never reach memory as an access, even if stale payload says so.
  assign out_mem_enable = head_mem_enable & out_valid;

  assign stalled = out_valid & ~out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stalled && !(&stall_count)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_xm_pipe_stage.sv
// Bench for xm_pipe_stage: directed scenarios plus randomized traffic checked
// against a capacity-2 FIFO model of the stage.
module tb_xm_pipe_stage;
  import xm_pipe_stage_pkg::*;

  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int PW  = $bits(xm_payload_t);
  localparam int SAT = (1 << SW) - 1;

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc, in_instr, in_address, in_data;
  logic          in_mem_read_write, in_mem_enable;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pc, out_instr, out_address, out_data;
  logic          out_mem_read_write, out_mem_enable;
  logic [SW-1:0] stall_count;

  int total;
  int bad;
  logic [PW-1:0] exp_q[$];
  int stall_exp;

  xm_pipe_stage #(
    .DATA_W      (DW),
    .STALL_CNT_W (SW)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_pc              (in_pc),
    .in_instr           (in_instr),
    .in_address         (in_address),
    .in_data            (in_data),
    .in_mem_read_write  (in_mem_read_write),
    .in_mem_enable      (in_mem_enable),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_pc             (out_pc),
    .out_instr          (out_instr),
    .out_address        (out_address),
    .out_data           (out_data),
    .out_mem_read_write (out_mem_read_write),
    .out_mem_enable     (out_mem_enable),
    .stall_count        (stall_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic v, input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                        input logic [DW-1:0] adr, input logic [DW-1:0] dat,
                        input logic rw, input logic en);
    in_valid          = v;
    in_pc             = pc;
    in_instr          = ins;
    in_address        = adr;
    in_data           = dat;
    in_mem_read_write = rw;
    in_mem_enable     = en;
  endtask

  task automatic set_rand_in(input logic v);
    set_in(v, $urandom, $urandom, $urandom, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [PW-1:0] cur_in();
    xm_payload_t p;
    p.pc             = in_pc;
    p.instr          = in_instr;
    p.address        = in_address;
    p.data           = in_data;
    p.mem_read_write = in_mem_read_write;
    p.mem_enable     = in_mem_enable;
    return p;
  endfunction

  // reference model: FIFO of at most two entries, head = exp_q[0]
  task automatic model_update();
    bit acc, con;
    acc = in_valid && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && out_ready;
    if (exp_q.size() > 0 && !out_ready && stall_exp < SAT) stall_exp++;
    if (flush) begin
      exp_q.delete();
    end else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(cur_in());
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    if (reset_n) model_update();
    #1;
  endtask

  // scoreboard comparison of every visible output against the model
  task automatic sample();
    xm_payload_t h;
    @(negedge clock);
    chk("out_valid", out_valid, exp_q.size() > 0);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("stall_count", stall_count, stall_exp);
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("out_mem_enable", out_mem_enable, h.mem_enable);
      chk("out_pc", out_pc, h.pc);
      chk("out_instr", out_instr, h.instr);
      chk("out_address", out_address, h.address);
      chk("out_data", out_data, h.data);
      chk("out_mem_read_write", out_mem_read_write, h.mem_read_write);
    end else begin
      chk("out_mem_enable_idle", out_mem_enable, 1'b0);
    end
  endtask

  // asynchronous reset, asserted away from the clock edge
  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    stall_exp = 0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mem_enable", out_mem_enable, 1'b0);
    chk("rst_stall_count", stall_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    stall_exp = 0;
    flush     = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 32'h1, 32'h2, 32'h3, 32'h4, MEM_WRITE, 1'b1);
    reset_n   = 1'b1;
    #2;

    // reset with in_valid held high, then idle
    do_reset();
    in_valid = 1'b0;
    sample();
    chk("idle_in_ready", in_ready, 1'b1);
    edge_step();

    // single transfer, then bubble gating after it is consumed
    set_in(1'b1, 32'h100, 32'hAC220004, 32'h2000, 32'hDEADBEEF, MEM_WRITE, 1'b1);
    out_ready = 1'b1;
    sample();
    edge_step();
    in_valid = 1'b0;
    sample();
    chk("single_valid", out_valid, 1'b1);
    chk("single_pc", out_pc, 32'h100);
    chk("single_instr", out_instr, 32'hAC220004);
    chk("single_address", out_address, 32'h2000);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_rw", out_mem_read_write, MEM_WRITE);
    chk("single_mem_en", out_mem_enable, 1'b1);
    edge_step();
    sample();
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_mem_en", out_mem_enable, 1'b0);
    edge_step();

    // back-pressure: two accepts fill the stage, then drain in order
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h0, 32'h11, 32'h20, 32'h30, MEM_READ, 1'b1);
    sample(); edge_step();
    set_in(1'b1, 32'h4, 32'h12, 32'h24, 32'h34, MEM_WRITE, 1'b1);
    sample(); edge_step();
    set_in(1'b1, 32'h8, 32'h13, 32'h28, 32'h38, MEM_READ, 1'b0);
    sample();
    chk("bp_in_ready_low", in_ready, 1'b0);
    edge_step();
    sample(); edge_step();
    sample();
    chk("bp_stall_count", stall_count, 3);
    chk("bp_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    edge_step();
    sample();
    chk("bp_drain_pc1", out_pc, 32'h4);
    edge_step();
    sample();
    chk("bp_drain_pc2", out_pc, 32'h8);
    in_valid = 1'b0;
    edge_step();
    sample();
    chk("bp_drained", out_valid, 1'b0);
    edge_step();

    // flush with full skid and a simultaneous offer
    do_reset();
    out_ready = 1'b0;
    set_in(1'b1, 32'h10, 32'h1, 32'h1, 32'h1, MEM_READ, 1'b1);
    sample(); edge_step();
    set_in(1'b1, 32'h14, 32'h2, 32'h2, 32'h2, MEM_READ, 1'b1);
    sample(); edge_step();
    set_in(1'b1, 32'h18, 32'h3, 32'h3, 32'h3, MEM_READ, 1'b1);
    flush = 1'b1;
    sample(); edge_step();
    flush    = 1'b0;
    in_valid = 1'b0;
    sample();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    edge_step();
    sample();
    chk("flush_stays_empty", out_valid, 1'b0);
    edge_step();

    // stall counter saturation
    do_reset();
    out_ready = 1'b0;
    set_rand_in(1'b1);
    sample(); edge_step();
    in_valid = 1'b0;
    repeat (20) begin
      sample(); edge_step();
    end
    sample();
    chk("sat_count", stall_count, SAT);
    edge_step();
    sample();
    chk("sat_hold", stall_count, SAT);
    out_ready = 1'b1;
    edge_step();

    // randomized traffic with a mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_rand_in($urandom_range(0, 3) != 0);
      out_ready = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      sample();
      edge_step();
      if (i == 150) begin
        flush = 1'b0;
        #2;
        do_reset();
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      sample(); edge_step();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
